// File: rtl/mem_access_unit.sv
// Load/store unit between the pipeline and a single-port data memory.
// Sub-word stores run read-modify-write through a one-word line buffer.
module mem_access_unit #(
  parameter logic [31:0] BASE_ADDR  = 32'd1024,
  parameter int unsigned WORD_COUNT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] memAdr,
  output logic [31:0] writeData,
  output logic        memRead,
  output logic        memWrite,
  input  logic [31:0] readData
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } state_t;

  localparam logic [32:0] LIMIT =
    {1'b0, BASE_ADDR} + 33'(4 * WORD_COUNT);

  state_t      state_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] buf_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic        wr_q;
  logic        err_q;

  logic        req_err;
  logic [31:0] merged;
  logic [31:0] lane;
  logic [31:0] ext;

  assign req_err =
      (req_size == 2'b11)
    | ((req_size == 2'b01) & req_addr[0])
    | ((req_size == 2'b10) & (|req_addr[1:0]))
    | (req_addr < BASE_ADDR)
    | ({1'b0, req_addr} >= LIMIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      buf_q   <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            wr_q    <= req_write;
            err_q   <= req_err;
            unique case (1'b1)
              req_err:
                state_q <= RESP;
              req_write && (req_size == 2'b10):
                state_q <= WRITE;
              default:
                state_q <= READ;
            endcase
          end
        end
        READ: begin
          buf_q   <= readData;
          state_q <= wr_q ? WRITE : RESP;
        end
        WRITE:   state_q <= RESP;
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Store data: splice the new lane into the buffered word
  always_comb begin
    merged = buf_q;
    case (size_q)
      2'b00:   merged[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
      2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  assign lane = buf_q >> {addr_q[1:0], 3'b000};

  always_comb begin
    ext = buf_q;
    case (size_q)
      2'b00:
        ext = uns_q ? {24'b0, lane[7:0]}
                    : {{24{lane[7]}}, lane[7:0]};
      2'b01:
        ext = uns_q ? {16'b0, lane[15:0]}
                    : {{16{lane[15]}}, lane[15:0]};
      default: ext = buf_q;
    endcase
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_err   = resp_valid & err_q;
  assign resp_rdata = (resp_valid & ~err_q & ~wr_q) ? ext : '0;
  assign memRead    = (state_q == READ);
  assign memWrite   = (state_q == WRITE);
  assign memAdr     = {addr_q[31:2], 2'b00};
  assign writeData  = memWrite ? merged : '0;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'd1024, first byte address of data memory.
REQ-002 SHALL have parameter WORD_COUNT, default 64, number of 32-bit words in data memory.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1  pipeline request present.
REQ-006 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_size  input  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-008 SHALL have port req_unsigned  input  1  load zero-extends when 1 and sign-extends when 0.
REQ-009 SHALL have port req_addr  input  32  byte address.
REQ-010 SHALL have port req_wdata  input  32  store data, with sub-word data in low bits.
REQ-011 SHALL have port req_ready  output  1  unit accepts a request this cycle.
REQ-012 SHALL have ports resp_valid  output  1, resp_rdata  output  32 and resp_err  output  1, forming a one-cycle response.
REQ-013 SHALL have ports memAdr  output  32, writeData  output  32, memRead  output  1 and memWrite  output  1, driving the data memory.
REQ-014 SHALL have port readData  input  32  combinational read data from the data memory.

Function
REQ-015 SHALL implement FSM states IDLE, READ, WRITE and RESP, with req_ready = 1 only in IDLE.
REQ-016 SHALL, in IDLE on req_valid = 1, register addr, wdata, size, unsigned and write, then evaluate errors.
REQ-017 SHALL raise an error for any of: size = 11, half with addr[0] = 1, word with addr[1:0] != 0, addr < BASE_ADDR, or addr >= BASE_ADDR + 4*WORD_COUNT.
REQ-018 SHALL route the next state on acceptance as: error -> RESP; word store -> WRITE; load or sub-word store -> READ.
REQ-019 SHALL, in READ, assert memRead = 1 with memAdr = {addr[31:2], 2'b00} and capture readData into a line buffer at the cycle's end.
REQ-020 SHALL, from READ, go to RESP for a load and to WRITE for a sub-word store.
REQ-021 SHALL, in WRITE, assert memWrite = 1 with memAdr as in REQ-019, then go to RESP.
REQ-022 SHALL drive writeData in WRITE as: full wdata for a word store; the buffer with the lane at byte addr[1:0] replaced by wdata[7:0] for a byte store; the buffer with half addr[1] replaced by wdata[15:0] for a half store.
REQ-023 SHALL use little-endian lanes: byte k occupies bits [8k+7:8k].
REQ-024 SHALL, for a load, extract the addressed byte, half or word from the buffer and extend it per req_unsigned to form resp_rdata.
REQ-025 SHALL, in RESP, hold resp_valid = 1 for exactly one cycle, then go to IDLE.
REQ-026 SHALL set resp_err = 1 only for errored requests, and resp_rdata = 0 for stores and for errors.
REQ-027 SHALL decode memRead and memWrite from the state register only; they are never both 1 and are 0 outside READ and WRITE.
REQ-028 SHALL hold writeData = 0 outside WRITE, and memAdr at the last registered aligned address.
REQ-029 SHALL perform no memory access (memRead = memWrite = 0 throughout) for an errored request.
REQ-030 SHALL meet latency, counted from the accept edge to the resp_valid cycle: error 1 cycle, word store 2, load 2, sub-word store 3.
REQ-031 SHALL ignore req_valid outside IDLE; the requester holds the request until req_ready = 1.
REQ-032 SHALL accept a new request in the IDLE cycle immediately following RESP.

Reset
REQ-033 SHALL, on rst = 0, immediately force state = IDLE and set req_ready = 1, resp_valid = 0, resp_err = 0, resp_rdata = 0, memRead = 0, memWrite = 0, memAdr = 0, writeData = 0 and the line buffer = 0.
REQ-034 SHALL, on reset mid-operation, drop the in-flight request with no response, deasserting memWrite asynchronously before the next negedge.

Verification
REQ-035 SHALL verify word store then load: store 0xDEADBEEF at 1028, then load word at 1028 -> resp_rdata = 0xDEADBEEF with resp_err = 0 and latency 2 for each.
REQ-036 SHALL verify byte read-modify-write: word 0x11223344 at 1032, then byte store 0xAA at 1033 -> memory word 0x1122AA44; signed byte load at 1033 -> 0xFFFFFFAA; unsigned load -> 0x000000AA.
REQ-037 SHALL verify half store and load: half store 0x8001 at 1034 over 0 -> word 0x80010000; signed half load at 1034 -> 0xFFFF8001.
REQ-038 SHALL verify errors: word load at 1030, load at 1023, load at 1280, and size = 11 -> each gives resp_err = 1 and resp_rdata = 0 after 1 cycle, with memRead and memWrite never asserted.
REQ-039 SHALL verify busy hold: req_valid held high during a sub-word store -> req_ready = 0 for 3 cycles and the second request is accepted in the IDLE cycle after RESP.
REQ-040 SHALL verify reset in WRITE: rst = 0 during WRITE -> memWrite = 0 immediately, no resp_valid, and the target word is unchanged.
